// File: rtl/fetch_unit.sv
// Instruction fetch sequencer (IDLE/RUN/DONE) driving a registered-output ROM with zero-bubble fetch.
// Optional macro FETCH_LUT_WR_EN makes the branch-target LUT writable outside RUN.
module fetch_unit #(
  parameter int              PCW     = 10,
  parameter int              IW      = 9,
  parameter logic [PCW-1:0]  LUT0    = 10'd0,
  parameter logic [PCW-1:0]  LUT1    = 10'd16,
  parameter logic [PCW-1:0]  LUT2    = 10'd64,
  parameter logic [PCW-1:0]  LUT3    = 10'd256,
  parameter logic [IW-1:0]   HALT_OP = 9'h1FF
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [PCW-1:0] Start_addr,
  input  logic           Stall,
  input  logic           Branch,
  input  logic           Taken,
  input  logic [1:0]     How_high,
  output logic [PCW-1:0] Imem_addr,
  input  logic [IW-1:0]  Imem_data,
  output logic [IW-1:0]  Instr,
  output logic           Instr_valid,
  output logic [PCW-1:0] PC,
  output logic           Done,
  output logic [15:0]    Cycle_count
`ifdef FETCH_LUT_WR_EN
  ,
  input  logic           Lut_we,
  input  logic [1:0]     Lut_idx,
  input  logic [PCW-1:0] Lut_wdata
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0][PCW-1:0] LUT_INIT = {LUT3, LUT2, LUT1, LUT0};

  state_t                state_q, state_d;
  logic [PCW-1:0]        pc_q, pc_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [3:0][PCW-1:0]   lut;

`ifdef FETCH_LUT_WR_EN
  logic [3:0][PCW-1:0]   lut_q;

  // Table is only rewritable while nothing is executing, so a branch never sees a half-updated target.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                           lut_q <= LUT_INIT;
    else if (Lut_we && state_q != S_RUN)  lut_q[Lut_idx] <= Lut_wdata;
  end

  assign lut = lut_q;
`else
  assign lut = LUT_INIT;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    Imem_addr = Start_addr;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = Start_addr;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        // Stall outranks halt so a HALT word is only acted on once the pipe may advance.
        if (Stall)                       pc_d = pc_q;
        else if (Imem_data == HALT_OP)   state_d = S_DONE;
        else if (Branch && Taken)        pc_d = lut[How_high];
        else                             pc_d = pc_q + PCW'(1);
        // Presenting the next PC to the ROM now means its word arrives exactly when PC updates.
        Imem_addr = pc_d;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Instr       = Imem_data;
  assign Instr_valid = (state_q == S_RUN);
  assign Done        = (state_q == S_DONE);
  assign PC          = pc_q;
  assign Cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a behavioural fetch model.
module tb_fetch_unit;
  localparam int PCW = 10;
  localparam int IW  = 9;
  localparam logic [IW-1:0] HALT = 9'h1FF;

  logic           Clk = 1'b0;
  logic           Reset, Start, Stall, Branch, Taken;
  logic [1:0]     How_high;
  logic [PCW-1:0] Start_addr, Imem_addr, PC;
  logic [IW-1:0]  Imem_data, Instr;
  logic           Instr_valid, Done;
  logic [15:0]    Cycle_count;
`ifdef FETCH_LUT_WR_EN
  logic           Lut_we;
  logic [1:0]     Lut_idx;
  logic [PCW-1:0] Lut_wdata;
`endif

  int checks = 0;
  int errors = 0;

  logic [IW-1:0]  rom [1024];
  bit             m_run, m_done;
  logic [PCW-1:0] m_pc;
  logic [PCW-1:0] m_lut [4];
  int             m_cnt;

  fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Start_addr(Start_addr),
    .Stall(Stall), .Branch(Branch), .Taken(Taken), .How_high(How_high),
    .Imem_addr(Imem_addr), .Imem_data(Imem_data), .Instr(Instr),
    .Instr_valid(Instr_valid), .PC(PC), .Done(Done), .Cycle_count(Cycle_count)
`ifdef FETCH_LUT_WR_EN
    , .Lut_we(Lut_we), .Lut_idx(Lut_idx), .Lut_wdata(Lut_wdata)
`endif
  );

  always #5 Clk = ~Clk;

  // Registered-output instruction ROM.
  always @(posedge Clk) Imem_data <= rom[Imem_addr];

  task automatic m_reset();
    m_run = 1'b0; m_done = 1'b0; m_pc = '0; m_cnt = 0;
    m_lut[0] = 10'd0; m_lut[1] = 10'd16; m_lut[2] = 10'd64; m_lut[3] = 10'd256;
  endtask

  // Address the fetcher should be presenting given the current inputs.
  function automatic logic [PCW-1:0] exp_addr();
    if (!m_run) return Start_addr;
    if (Stall || rom[m_pc] == HALT) return m_pc;
    if (Branch && Taken) return m_lut[How_high];
    return m_pc + 10'd1;
  endfunction

  // One clock: advance the model with the inputs held across the edge, return at the falling edge.
  task automatic step();
    @(posedge Clk);
    if (!m_run) begin
`ifdef FETCH_LUT_WR_EN
      if (Lut_we) m_lut[Lut_idx] = Lut_wdata;
`endif
      if (Start) begin m_run = 1'b1; m_done = 1'b0; m_pc = Start_addr; m_cnt = 0; end
    end else begin
      if (m_cnt < 65535) m_cnt++;
      if (!Stall) begin
        if (rom[m_pc] == HALT) begin m_run = 1'b0; m_done = 1'b1; end
        else if (Branch && Taken) m_pc = m_lut[How_high];
        else m_pc = m_pc + 10'd1;
      end
    end
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    Start = 0; Stall = 0; Branch = 0; Taken = 0; How_high = 0;
`ifdef FETCH_LUT_WR_EN
    Lut_we = 0; Lut_idx = 0; Lut_wdata = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 0; #2; Reset = 1; m_reset();
    @(negedge Clk);
  endtask

  task automatic start_at(input logic [PCW-1:0] a);
    Start_addr = a; Start = 1; step(); Start = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); Start_addr = 10'd7; Reset = 0; m_reset();
    #1;
    checks++; if (PC !== 10'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", PC); end
    checks++; if (Instr_valid !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL reset_flags got v=%b d=%b exp 0 0", Instr_valid, Done); end
    checks++; if (Cycle_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", Cycle_count); end
    checks++; if (Imem_addr !== 10'd7) begin errors++; $display("FAIL reset_imem_addr got %0d exp 7", Imem_addr); end
    @(negedge Clk); Reset = 1; step();
    checks++; if (Instr_valid !== 1'b0) begin errors++; $display("FAIL idle_hold got v=%b exp 0", Instr_valid); end
  endtask

  task automatic test_sequential();
    do_reset(); start_at(10'd5);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (PC !== 10'(5 + i) || Instr_valid !== 1'b1) begin errors++; $display("FAIL seq_pc[%0d] got %0d v=%b exp %0d v=1", i, PC, Instr_valid, 5 + i); end
      checks++; if (Imem_addr !== 10'(6 + i)) begin errors++; $display("FAIL seq_addr[%0d] got %0d exp %0d", i, Imem_addr, 6 + i); end
      checks++; if (Instr !== rom[5 + i]) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", i, Instr, rom[5 + i]); end
      step();
    end
  endtask

  task automatic test_reset_midrun();
    do_reset(); start_at(10'd30);
    repeat (7) step();
    checks++; if (PC !== 10'd37) begin errors++; $display("FAIL midrun_pre_pc got %0d exp 37", PC); end
    #2; Reset = 0; #1;
    checks++; if (PC !== 10'd0 || Instr_valid !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL midrun_async got pc=%0d v=%b d=%b exp 0 0 0", PC, Instr_valid, Done); end
    checks++; if (Cycle_count !== 16'd0) begin errors++; $display("FAIL midrun_cnt got %0d exp 0", Cycle_count); end
    Reset = 1; m_reset(); @(negedge Clk);
    Start_addr = 10'd99; #1;
    checks++; if (Instr_valid !== 1'b0 || Imem_addr !== 10'd99) begin errors++; $display("FAIL midrun_idle got v=%b addr=%0d exp 0 99", Instr_valid, Imem_addr); end
  endtask

  task automatic test_branch();
    do_reset(); start_at(10'd12);
    Branch = 1; Taken = 1; How_high = 2; #1;
    checks++; if (Imem_addr !== 10'd64) begin errors++; $display("FAIL br_addr got %0d exp 64", Imem_addr); end
    step();
    checks++; if (PC !== 10'd64 || Instr !== rom[64]) begin errors++; $display("FAIL br_taken got pc=%0d i=%h exp 64 %h", PC, Instr, rom[64]); end
    do_reset(); start_at(10'd12);
    Branch = 1; Taken = 0; How_high = 2; step();
    checks++; if (PC !== 10'd13) begin errors++; $display("FAIL br_not_taken got %0d exp 13", PC); end
    Branch = 0; Taken = 1; How_high = 3; step();
    checks++; if (PC !== 10'd14) begin errors++; $display("FAIL taken_no_branch got %0d exp 14", PC); end
  endtask

  task automatic test_stall();
    do_reset(); start_at(10'd20);
    Stall = 1; Branch = 1; Taken = 1; How_high = 3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (Imem_addr !== 10'd20) begin errors++; $display("FAIL stall_addr[%0d] got %0d exp 20", i, Imem_addr); end
      step();
      checks++; if (PC !== 10'd20 || Instr !== rom[20]) begin errors++; $display("FAIL stall_hold[%0d] got pc=%0d i=%h exp 20 %h", i, PC, Instr, rom[20]); end
    end
    checks++; if (Cycle_count !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", Cycle_count); end
    Stall = 0; #1;
    checks++; if (Imem_addr !== 10'd256) begin errors++; $display("FAIL stall_release_addr got %0d exp 256", Imem_addr); end
    step();
    checks++; if (PC !== 10'd256 || Cycle_count !== 16'd4) begin errors++; $display("FAIL stall_release got pc=%0d c=%0d exp 256 4", PC, Cycle_count); end
  endtask

  task automatic test_halt();
    logic [IW-1:0] saved;
    saved = rom[40]; rom[40] = HALT;
    do_reset(); start_at(10'd38); step(); step();
    Stall = 1; step(); step();
    checks++; if (PC !== 10'd40 || Instr_valid !== 1'b1 || Done !== 1'b0) begin errors++; $display("FAIL halt_stalled got pc=%0d v=%b d=%b exp 40 1 0", PC, Instr_valid, Done); end
    Stall = 0; #1;
    checks++; if (Imem_addr !== 10'd40) begin errors++; $display("FAIL halt_addr got %0d exp 40", Imem_addr); end
    step();
    Start_addr = 10'd77; #1;
    checks++; if (Done !== 1'b1 || Instr_valid !== 1'b0 || PC !== 10'd40) begin errors++; $display("FAIL halt_done got d=%b v=%b pc=%0d exp 1 0 40", Done, Instr_valid, PC); end
    checks++; if (Imem_addr !== 10'd77 || Cycle_count !== 16'd5) begin errors++; $display("FAIL halt_done_addr got a=%0d c=%0d exp 77 5", Imem_addr, Cycle_count); end
    step();
    checks++; if (Cycle_count !== 16'd5 || Done !== 1'b1) begin errors++; $display("FAIL done_hold got c=%0d d=%b exp 5 1", Cycle_count, Done); end
    start_at(10'd77);
    checks++; if (PC !== 10'd77 || Cycle_count !== 16'd0 || Done !== 1'b0 || Instr_valid !== 1'b1) begin errors++; $display("FAIL restart got pc=%0d c=%0d d=%b v=%b exp 77 0 0 1", PC, Cycle_count, Done, Instr_valid); end
    rom[40] = saved;
  endtask

  task automatic test_wrap();
    do_reset(); start_at(10'h3FF);
    Start_addr = 10'd3; Start = 1; step(); Start = 0;
    checks++; if (PC !== 10'd0 || Instr !== rom[0]) begin errors++; $display("FAIL wrap got pc=%0d i=%h exp 0 %h", PC, Instr, rom[0]); end
  endtask

`ifdef FETCH_LUT_WR_EN
  task automatic test_lut_write();
    do_reset();
    Lut_we = 1; Lut_idx = 1; Lut_wdata = 10'd300; step(); Lut_we = 0;
    start_at(10'd12);
    Branch = 1; Taken = 1; How_high = 1; step();
    checks++; if (PC !== 10'd300) begin errors++; $display("FAIL lut_wr got %0d exp 300", PC); end
    Branch = 0; Lut_we = 1; Lut_idx = 1; Lut_wdata = 10'd500; step(); Lut_we = 0;
    Branch = 1; Taken = 1; How_high = 1; step();
    checks++; if (PC !== 10'd300) begin errors++; $display("FAIL lut_wr_run got %0d exp 300", PC); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 40; i++) rom[$urandom_range(0, 1023)] = HALT;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      Start      = ($urandom_range(0, 5) == 0);
      Start_addr = PCW'($urandom_range(0, 1023));
      Stall      = ($urandom_range(0, 3) == 0);
      Branch     = ($urandom_range(0, 3) == 0);
      Taken      = $urandom_range(0, 1) == 1;
      How_high   = 2'($urandom_range(0, 3));
`ifdef FETCH_LUT_WR_EN
      Lut_we     = ($urandom_range(0, 7) == 0);
      Lut_idx    = 2'($urandom_range(0, 3));
      Lut_wdata  = PCW'($urandom_range(0, 1023));
`endif
      #1;
      checks++; if (Imem_addr !== exp_addr()) begin errors++; $display("FAIL rnd_addr@%0d got %0d exp %0d", n, Imem_addr, exp_addr()); end
      checks++; if (PC !== m_pc || Instr_valid !== m_run || Done !== m_done) begin errors++; $display("FAIL rnd_state@%0d got pc=%0d v=%b d=%b exp %0d %b %b", n, PC, Instr_valid, Done, m_pc, m_run, m_done); end
      checks++; if (Cycle_count !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt@%0d got %0d exp %0d", n, Cycle_count, m_cnt); end
      if (m_run) begin
        checks++; if (Instr !== rom[m_pc]) begin errors++; $display("FAIL rnd_instr@%0d got %h exp %h", n, Instr, rom[m_pc]); end
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = IW'($urandom_range(0, 9'h1FE));
    test_reset();
    test_sequential();
    test_reset_midrun();
    test_branch();
    test_stall();
    test_halt();
    test_wrap();
`ifdef FETCH_LUT_WR_EN
    test_lut_write();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PCW, default 10, program-counter/instruction-address width.
REQ-002 Parameter IW, default 9, machine-code width.
REQ-003 Parameters LUT0..LUT3, default 10'd0/10'd16/10'd64/10'd256, absolute branch targets indexed by How_high.
REQ-004 Parameter HALT_OP, default 9'h1FF, opcode that ends execution.
REQ-005 Clk  in  1  single clock; all state on rising edge.
REQ-006 Reset  in  1  asynchronous, active-low; low forces reset state immediately.
REQ-007 Start  in  1  one-cycle pulse; begins execution at Start_addr.
REQ-008 Start_addr  in  PCW  first instruction address.
REQ-009 Stall  in  1  hold PC and current instruction.
REQ-010 Branch  in  1  branch decode from control decoder.
REQ-011 Taken  in  1  ALU branch condition.
REQ-012 How_high  in  2  branch-target LUT index.
REQ-013 Imem_addr  out  PCW  combinational next-fetch address to registered-output instruction ROM.
REQ-014 Imem_data  in  IW  ROM word; equals ROM[Imem_addr of previous cycle].
REQ-015 Instr  out  IW  current instruction (Imem_data pass-through) to control decoder.
REQ-016 Instr_valid  out  1  high only in RUN.
REQ-017 PC  out  PCW  address of current Instr.
REQ-018 Done  out  1  high in DONE state.
REQ-019 Cycle_count  out  16  RUN cycles since last Start, saturating at 16'hFFFF.

Function
REQ-020 FSM states IDLE, RUN, DONE; exactly one active.
REQ-021 IDLE: Imem_addr=Start_addr; Start=1 -> RUN, PC<=Start_addr, Cycle_count<=0.
REQ-022 RUN, priority order: Stall -> PC held, Imem_addr=PC; else Instr==HALT_OP -> DONE, PC held; else Branch&Taken -> PC<=LUT[How_high]; else PC<=PC+1.
REQ-023 Imem_addr in RUN SHALL equal the next-cycle PC value, giving zero-bubble fetch including taken branches.
REQ-024 PC+1 wraps modulo 2^PCW (max address -> 0), no flag.
REQ-025 Branch with Taken=0 behaves as sequential fetch; Taken ignored when Branch=0.
REQ-026 Start while in RUN ignored; Start in DONE -> RUN, identical to IDLE entry.
REQ-027 DONE: Done=1, Instr_valid=0, PC holds halt address, Imem_addr=Start_addr.
REQ-028 Cycle_count increments every RUN cycle including stalled cycles; holds in IDLE/DONE.
REQ-029 Halt detection suppressed while Stall=1; HALT_OP recognised on first unstalled cycle.

Reset
REQ-030 Reset low: state IDLE, PC=0, Cycle_count=0, Instr_valid=0, Done=0, LUT reloaded from parameters; mid-RUN reset abandons execution without completing current instruction.
REQ-031 Outputs reach reset values asynchronously; first transition possible on first rising Clk after Reset high.

Configuration
REQ-032 Macro FETCH_LUT_WR_EN defined: ports Lut_we(1), Lut_idx(2), Lut_wdata(PCW) added; LUT is a register file written on rising edge when Lut_we=1 in IDLE or DONE; writes in RUN ignored.
REQ-033 Macro undefined: write ports absent; LUT fixed to LUT0..LUT3.

Verification
REQ-034 Reset low mid-RUN at PC=10'd37 -> same cycle PC=0, Instr_valid=0, Done=0; after release IDLE, Imem_addr=Start_addr.
REQ-035 Start pulse with Start_addr=10'd5, no branches -> PC sequence 5,6,7,8 on consecutive cycles, Instr_valid=1, Imem_addr always one ahead.
REQ-036 In RUN at PC=12, Branch=1, Taken=1, How_high=2 -> next cycle PC=64, no bubble; same with Taken=0 -> PC=13.
REQ-037 Stall=1 three cycles at PC=20 with Branch=Taken=1 -> PC stays 20, Instr unchanged, Cycle_count +3; release -> branch then taken.
REQ-038 Instr=9'h1FF at PC=40 -> next cycle DONE, Done=1, Instr_valid=0, PC=40; Start -> RUN, Cycle_count cleared.
REQ-039 PC=10'h3FF sequential -> next PC=0; with FETCH_LUT_WR_EN, write idx1=10'd300 in IDLE then taken branch How_high=1 -> PC=300; write during RUN -> LUT unchanged.
